// File: rtl/background_plotter.sv
// Frame-sweep reader: walks a 160x120 background ROM with a vertical scroll
// offset and emits a one-pixel-per-clock x/y/colour/plot stream for the VGA adapter.
module background_plotter #(
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120,
  parameter int ADDR_W  = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        scroll_offset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [7:0]        colour,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [6:0]        r_off;
  logic [7:0]        r_sx;
  logic [6:0]        r_sy;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [7:0]        r_x;
  logic [6:0]        r_y;
  logic [7:0]        r_colour_hold;
  logic              r_plot;
  logic              r_busy;
  logic              r_done;

  logic              w_idle;
  logic              w_last_col;
  logic              w_last_pixel;
  logic [6:0]        w_start_off;
  logic [7:0]        w_sx_next;
  logic [6:0]        w_sy_next;
  logic [6:0]        w_addr_row;
  logic [7:0]        w_addr_col;
  logic [6:0]        w_addr_off;
  logic [7:0]        w_row_sum;
  logic [7:0]        w_src_row;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_idle       = (r_state == S_IDLE);
  assign w_last_col   = (r_sx == 8'(XSCREEN - 1));
  assign w_last_pixel = w_last_col && (r_sy == 7'(YSCREEN - 1));
  assign w_start_off  = (scroll_offset >= 7'(YSCREEN)) ? 7'd0 : scroll_offset;

  assign w_sx_next = w_last_col ? 8'd0 : r_sx + 8'd1;
  assign w_sy_next = w_last_col ? r_sy + 7'd1 : r_sy;

  // On an accepted start the first address (0,0) is formed from the incoming offset.
  assign w_addr_row = w_idle ? 7'd0 : w_sy_next;
  assign w_addr_col = w_idle ? 8'd0 : w_sx_next;
  assign w_addr_off = w_idle ? w_start_off : r_off;

  assign w_row_sum   = {1'b0, w_addr_row} + {1'b0, w_addr_off};
  assign w_src_row   = (w_row_sum >= 8'(YSCREEN)) ? w_row_sum - 8'(YSCREEN) : w_row_sum;
  assign w_next_addr = ADDR_W'(w_src_row) * ADDR_W'(XSCREEN) + ADDR_W'(w_addr_col);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_off         <= 7'd0;
      r_sx          <= 8'd0;
      r_sy          <= 7'd0;
      r_rom_addr    <= '0;
      r_x           <= 8'd0;
      r_y           <= 7'd0;
      r_colour_hold <= 8'd0;
      r_plot        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_plot) r_colour_hold <= rom_data;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_off      <= w_start_off;
            r_sx       <= 8'd0;
            r_sy       <= 7'd0;
            r_rom_addr <= w_next_addr;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          // x/y trail the address by one stage to line up with the synchronous ROM.
          r_plot <= 1'b1;
          r_x    <= r_sx;
          r_y    <= r_sy;
          if (w_last_pixel) begin
            r_state <= S_FLUSH;
          end else begin
            r_sx       <= w_sx_next;
            r_sy       <= w_sy_next;
            r_rom_addr <= w_next_addr;
          end
        end
        S_FLUSH: begin
          r_plot  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr = r_rom_addr;
  assign x        = r_x;
  assign y        = r_y;
  assign colour   = r_plot ? rom_data : r_colour_hold;
  assign plot     = r_plot;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_background_plotter.sv
// Directed bench for background_plotter: frame timing, scrolled addressing,
// offset latching, dropped starts, mid-frame reset and back-to-back frames.
module tb_background_plotter;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  scroll_offset;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [7:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  background_plotter #(.XSCREEN(160), .YSCREEN(120), .ADDR_W(15)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .start         (start),
    .scroll_offset (scroll_offset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .busy          (busy),
    .done          (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous ROM model: colour = low byte of the address.
  always @(posedge CLOCK_50) rom_data <= rom_addr[7:0];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  int          first_t, n_plot, gaps, done_t, n_done, addr_err, colour_err, late_plots;
  int          busy_at1, busy_at_done;
  int          seen_addr [0:19199];
  logic [14:0] prev_addr;

  // Runs one frame; t counts negedges after the one where start is driven.
  task automatic run_frame(input logic [6:0] off_in, input int exp_off, input int change_t,
                           input int extra_t, input int abort_t, input int tail);
    int t;
    int exp_a;
    bit fin;
    first_t = -1; n_plot = 0; gaps = 0; done_t = -1; n_done = 0;
    addr_err = 0; colour_err = 0; late_plots = 0; busy_at1 = -1; busy_at_done = -1;
    for (int i = 0; i < 19200; i++) seen_addr[i] = -1;
    @(negedge CLOCK_50);
    start = 1'b1;
    scroll_offset = off_in;
    prev_addr = rom_addr;
    t = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge CLOCK_50);
      t++;
      if (t == 1) begin
        start = 1'b0;
        busy_at1 = int'(busy);
      end
      if (t == change_t) scroll_offset = 7'd50;
      if (t == extra_t) start = 1'b1;
      if (t == extra_t + 1) start = 1'b0;
      if (plot) begin
        if (done_t >= 0) begin
          late_plots++;
        end else begin
          if (first_t < 0) first_t = t;
          if (t != first_t + n_plot) gaps++;
          n_plot++;
          exp_a = ((int'(y) + exp_off) % 120) * 160 + int'(x);
          if (int'(prev_addr) != exp_a) addr_err++;
          if (int'(colour) != (exp_a % 256)) colour_err++;
          if (x < 8'd160 && y < 7'd120) seen_addr[int'(y) * 160 + int'(x)] = int'(prev_addr);
        end
      end
      if (done) begin
        n_done++;
        if (done_t < 0) begin
          done_t = t;
          busy_at_done = int'(busy);
        end
      end
      prev_addr = rom_addr;
      if (t == abort_t) begin
        reset = 1'b1;
        #1;
        check("abort_plot_async", plot, 0);
        check("abort_busy_async", busy, 0);
        repeat (3) begin
          @(negedge CLOCK_50);
          if (done) n_done++;
        end
        reset = 1'b0;
        repeat (5) begin
          @(negedge CLOCK_50);
          if (done) n_done++;
          if (plot) late_plots++;
        end
        fin = 1'b1;
      end
      if (done_t >= 0 && t >= done_t + tail) fin = 1'b1;
      if (t > 19400) begin
        check("frame_timeout_cycles", t, 19400);
        fin = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    scroll_offset = 7'd0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_colour", colour, 0);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check("idle_busy", busy, 0);

    // Frame 1: offset 10, offset changed and a stray start at pixel 1000.
    run_frame(7'd10, 10, 1002, 1002, -1, 40);
    check("f1_first_plot_t", first_t, 2);
    check("f1_plot_count", n_plot, 19200);
    check("f1_gaps", gaps, 0);
    check("f1_done_t", done_t, 19202);
    check("f1_done_pulses", n_done, 1);
    check("f1_extra_frame_plots", late_plots, 0);
    check("f1_addr_errors", addr_err, 0);
    check("f1_colour_errors", colour_err, 0);
    check("f1_addr_row0", seen_addr[0], 1600);
    check("f1_addr_row110", seen_addr[110 * 160], 0);
    check("f1_addr_row119", seen_addr[119 * 160], 1440);
    check("f1_busy_after_start", busy_at1, 1);
    check("f1_busy_at_done", busy_at_done, 0);
    check("f1_hold_x", x, 159);
    check("f1_hold_y", y, 119);
    check("f1_hold_rom_addr", rom_addr, 1599);
    check("f1_idle_plot", plot, 0);

    // Frame 2: out-of-range offset 127 acts as 0; reset at pixel 5000.
    repeat (3) @(negedge CLOCK_50);
    run_frame(7'd127, 0, -1, -1, 5002, 0);
    check("f2_plot_count_before_abort", n_plot, 5001);
    check("f2_done_pulses", n_done, 0);
    check("f2_plots_after_reset", late_plots, 0);
    check("f2_addr_errors", addr_err, 0);
    check("f2_colour_errors", colour_err, 0);
    check("f2_addr_x0_y0", seen_addr[0], 0);
    check("f2_addr_x5_y1", seen_addr[165], 165);
    check("f2_busy_after_abort", busy, 0);

    // Frame 3 (offset 0) then frame 4 (offset 119) started the cycle after done.
    repeat (3) @(negedge CLOCK_50);
    run_frame(7'd0, 0, -1, -1, -1, 0);
    check("f3_first_plot_t", first_t, 2);
    check("f3_plot_count", n_plot, 19200);
    check("f3_done_t", done_t, 19202);
    check("f3_addr_first", seen_addr[0], 0);
    check("f3_addr_last", seen_addr[19199], 19199);
    check("f3_addr_errors", addr_err, 0);

    run_frame(7'd119, 119, -1, -1, -1, 10);
    check("f4_first_plot_t", first_t, 2);
    check("f4_plot_count", n_plot, 19200);
    check("f4_gaps", gaps, 0);
    check("f4_done_t", done_t, 19202);
    check("f4_done_pulses", n_done, 1);
    check("f4_addr_x5_y0", seen_addr[5], 19045);
    check("f4_addr_x5_y1", seen_addr[165], 5);
    check("f4_addr_errors", addr_err, 0);
    check("f4_colour_errors", colour_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/background_plotter.md
Name: background_plotter

Overview:
- Frame-sweep reader that fills the 160x120 VGA adapter buffer from a background image ROM.
- It applies a vertical scroll offset, so the screen row shown is (row + offset) mod YSCREEN.
- It produces the x/y/colour/plot write stream that the vga_adapter consumes, one pixel per clock.
- It sits between the speed/scroll control logic and vga_adapter. It is triggered once per frame tick.

Parameters:
- XSCREEN, 160, pixels per row.
- YSCREEN, 120, rows per frame.
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= XSCREEN*YSCREEN.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to plot one full frame; ignored while busy.
- scroll_offset  in  7  vertical offset, sampled on accepted start.
- rom_addr  out  ADDR_W  background ROM read address.
- rom_data  in  8  ROM colour, valid exactly 1 cycle after rom_addr (synchronous ROM).
- x  out  8  plot column, to vga_adapter.x.
- y  out  7  plot row (screen coordinate), to vga_adapter.y.
- colour  out  8  plot colour, to vga_adapter.colour.
- plot  out  1  write strobe; one pixel is written per cycle it is high.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last pixel is plotted.

Behaviour:
- Reset (async, immediate): all outputs are 0 (rom_addr, x, y, colour, plot, busy, done); state is IDLE; latched offset is 0.
- State machine:
  - IDLE: on start=1, latch off = (scroll_offset >= YSCREEN) ? 0 : scroll_offset. Clear the sweep counters sx=0, sy=0. Go to RUN and set busy=1.
  - RUN: each cycle, present rom_addr = src_row*XSCREEN + sx, where src_row = sy + off, minus YSCREEN if the sum >= YSCREEN. Compute src_row with a compare/subtract, not a modulo operator, at a width of 8 bits or more.
  - RUN counter advance: sx increments. When sx = XSCREEN-1, sx becomes 0 and sy increments. After addressing (XSCREEN-1, YSCREEN-1), go to FLUSH.
  - FLUSH: one cycle to plot the final ROM word. Then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Pipeline and latency:
  - The pixel addressed in cycle n is plotted in cycle n+1, with x/y delayed one stage so they align with rom_data.
  - plot=1 with x=sx(n-1), y=sy(n-1), colour=rom_data.
  - The first plot is 2 cycles after the start cycle.
  - plot is high for exactly XSCREEN*YSCREEN = 19200 consecutive cycles, with no gaps.
  - done rises the cycle after the last plot, i.e. 19202 cycles after start.
- Output coordinates: x and y are screen coordinates, not scrolled. Only rom_addr is scrolled.
- Offset handling:
  - scroll_offset changes during a frame have no effect; the offset is latched once per frame.
  - start during busy (including the DONE cycle) is dropped, not queued.
- Outside a frame: when plot=0, x, y and colour hold their last values. rom_addr holds its value in IDLE.
- Wrap boundary: with off=119, screen row 0 reads ROM row 119 and screen row 1 reads ROM row 0.
- Reset mid-frame: plot and busy drop asynchronously, no done pulse is produced, and the next start begins a fresh frame at (0,0).

Test Plan:
- Reset then start with scroll_offset=0 -> first plot at start+2 with x=0, y=0, rom_addr in the previous cycle = 0. Last plot has x=159, y=119, preceding rom_addr = 19199. Exactly 19200 plot cycles; done is a single pulse at start+19202.
- scroll_offset=10 -> screen row 0 reads addr 1600. Screen row 110 reads addr 0. Screen row 119 reads addr 1440. With a ROM model colour = addr[7:0], every plotted colour matches the formula.
- scroll_offset=119 -> (x=5,y=0) reads addr 19045; (x=5,y=1) reads addr 5. scroll_offset=127 (out of range) -> behaves as offset 0.
- Change scroll_offset from 0 to 50 mid-frame, and pulse start at pixel 1000 -> the whole frame uses offset 0. The extra start is ignored: exactly one done pulse and no second frame.
- Assert reset at pixel 5000 for 3 cycles -> plot and busy are 0 within the reset cycle (asynchronous), with no done pulse. A new start then replots from (0,0) with the full 19200 pixels.
- Back-to-back: pulse start in the cycle after done -> accepted. The second frame timing is identical to the first.
